// File: rtl/pc_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl_pkg
// Shared definitions for the fetch-steering controller:
//   state_t        - controller FSM state encoding
//   src_t          - redirect source encoding produced by the arbiter
//   PC_ALIGN_MASK  - clears bits [1:0] of any redirect target
// ---------------------------------------------------------------------------
package pc_redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MX_WAIT  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_TRAP = 3'd1,
      SRC_MRET = 3'd2,
      SRC_BR   = 3'd3,
      SRC_JAL  = 3'd4
   } src_t;

   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_redirect_ctrl_redirect_arb.sv
// ---------------------------------------------------------------------------
// redirect_arb
// Combinational fixed-priority select among the four redirect requesters.
// Priority: trap > mret > EX branch > ID jal.
// Ports:
//   trap_req/trap_vec     exception/interrupt request and target
//   mret_req/mepc         mret request and target
//   br_taken/br_target    resolved EX branch request and target
//   jal/jal_target        ID jal request (already qualified by caller) and target
//   valid                 some requester is active
//   src                   winning source (src_t encoding)
//   target                winning target, unaligned
// ---------------------------------------------------------------------------
module redirect_arb
   import pc_redirect_ctrl_pkg::*;
(
   input  logic        trap_req,
   input  logic [31:0] trap_vec,
   input  logic        mret_req,
   input  logic [31:0] mepc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jal,
   input  logic [31:0] jal_target,
   output logic        valid,
   output logic [2:0]  src,
   output logic [31:0] target
);

   always_comb begin
      valid  = 1'b1;
      src    = SRC_NONE;
      target = 32'd0;
      if (trap_req) begin
         src    = SRC_TRAP;
         target = trap_vec;
      end else if (mret_req) begin
         src    = SRC_MRET;
         target = mepc;
      end else if (br_taken) begin
         src    = SRC_BR;
         target = br_target;
      end else if (jal) begin
         src    = SRC_JAL;
         target = jal_target;
      end else begin
         valid  = 1'b0;
      end
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
// Fetch-steering controller: drives the PC redirect/stall inputs and the
// IF/ID, ID/EX stall/flush controls; sequences load-use and matrix stalls.
// Ports:
//   clk, rst (async, active low)
//   trap_req/trap_vec, mret_req/mepc, ex_br_taken/ex_br_target,
//   id_jal/id_jal_target       redirect requesters
//   id_load_use                load-use hazard in ID
//   mx_start, mx_done          matrix issue / completion
//   br_ctrl, br_addr, pc_stall PC controls (combinational)
//   if_id_stall, if_id_flush, id_ex_flush   pipeline register controls
//   mx_kill                    abort pulse to the matrix unit
//   mx_timeout                 sticky matrix timeout flag
// ---------------------------------------------------------------------------
module pc_redirect_ctrl
   import pc_redirect_ctrl_pkg::*;
#(
   parameter int LOAD_LAT   = 1,
   parameter int MX_TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        trap_req,
   input  logic [31:0] trap_vec,
   input  logic        mret_req,
   input  logic [31:0] mepc,
   input  logic        ex_br_taken,
   input  logic [31:0] ex_br_target,
   input  logic        id_jal,
   input  logic [31:0] id_jal_target,
   input  logic        id_load_use,
   input  logic        mx_start,
   input  logic        mx_done,
   output logic        br_ctrl,
   output logic [31:0] br_addr,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        mx_kill,
   output logic        mx_timeout
);

   localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);
   localparam logic [7:0] TO_MAX  = 8'(MX_TIMEOUT);

   state_t      state;
   logic [2:0]  cnt;
   logic [7:0]  tcnt;
   logic [7:0]  tcnt_inc;
   logic        kill_pulse;
   logic        timeout_flag;

   logic        redir_valid;
   logic [2:0]  redir_src;
   logic [31:0] redir_target;
   logic        hard_redir;
   logic        stall_now;

   // The ID instruction is frozen outside RUN, so its jal must not redirect.
   redirect_arb u_arb (
      .trap_req   (trap_req),
      .trap_vec   (trap_vec),
      .mret_req   (mret_req),
      .mepc       (mepc),
      .br_taken   (ex_br_taken),
      .br_target  (ex_br_target),
      .jal        (id_jal && (state == ST_RUN)),
      .jal_target (id_jal_target),
      .valid      (redir_valid),
      .src        (redir_src),
      .target     (redir_target)
   );

   // Trap, mret and EX branch flush both stages; jal only the fetched slot.
   assign hard_redir = redir_valid && (redir_src != SRC_JAL);

   // Saturating increment so tcnt never wraps past the timeout value.
   assign tcnt_inc = (tcnt == TO_MAX) ? tcnt : tcnt + 8'd1;

   always_comb begin
      stall_now = 1'b0;
      case (state)
         ST_RUN:      stall_now = id_load_use && !mx_start;
         ST_LU_STALL: stall_now = 1'b1;
         ST_MX_WAIT:  stall_now = 1'b1;
         default:     stall_now = 1'b0;
      endcase
   end

   // Combinational outputs are gated by rst so that they drop immediately
   // when reset asserts, independent of the requesters.
   assign br_ctrl     = rst && redir_valid;
   assign br_addr     = rst ? (redir_target & PC_ALIGN_MASK) : 32'd0;
   assign pc_stall    = rst && !redir_valid && stall_now;
   assign if_id_stall = rst && !redir_valid && stall_now;
   assign if_id_flush = rst && redir_valid;
   assign id_ex_flush = rst && (hard_redir || (!redir_valid && stall_now));
   assign mx_kill     = rst && (kill_pulse || (hard_redir && (state == ST_MX_WAIT)));
   assign mx_timeout  = rst && timeout_flag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_RUN;
         cnt          <= 3'd0;
         tcnt         <= 8'd0;
         kill_pulse   <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         kill_pulse <= 1'b0;
         if (redir_valid) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
            tcnt  <= 8'd0;
         end else begin
            case (state)
               ST_RUN: begin
                  if (mx_start) begin
                     state <= ST_MX_WAIT;
                     tcnt  <= 8'd0;
                  end else if (id_load_use && (LOAD_LAT > 1)) begin
                     state <= ST_LU_STALL;
                     cnt   <= LU_INIT;
                  end
               end
               ST_LU_STALL: begin
                  if (cnt <= 3'd1) begin
                     state <= ST_RUN;
                     cnt   <= 3'd0;
                  end else begin
                     cnt <= cnt - 3'd1;
                  end
               end
               ST_MX_WAIT: begin
                  if (mx_done) begin
                     state <= ST_RUN;
                     tcnt  <= 8'd0;
                  end else if (tcnt_inc == TO_MAX) begin
                     // Kill is registered, so it shows in the first RUN cycle.
                     state        <= ST_RUN;
                     tcnt         <= 8'd0;
                     kill_pulse   <= 1'b1;
                     timeout_flag <= 1'b1;
                  end else begin
                     tcnt <= tcnt_inc;
                  end
               end
               default: begin
                  state <= ST_RUN;
                  cnt   <= 3'd0;
                  tcnt  <= 8'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
// Directed bench. Instance a: LOAD_LAT=3, MX_TIMEOUT=255.
// Instance b: LOAD_LAT=1, MX_TIMEOUT=4. Both share all inputs.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        trap_req, mret_req, ex_br_taken, id_jal;
   logic        id_load_use, mx_start, mx_done;
   logic [31:0] trap_vec, mepc, ex_br_target, id_jal_target;

   logic        br_ctrl_a, pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_flush_a;
   logic        mx_kill_a, mx_timeout_a;
   logic [31:0] br_addr_a;
   logic        br_ctrl_b, pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_flush_b;
   logic        mx_kill_b, mx_timeout_b;
   logic [31:0] br_addr_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.LOAD_LAT(3), .MX_TIMEOUT(255)) dut_a (
      .clk(clk), .rst(rst),
      .trap_req(trap_req), .trap_vec(trap_vec),
      .mret_req(mret_req), .mepc(mepc),
      .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
      .id_jal(id_jal), .id_jal_target(id_jal_target),
      .id_load_use(id_load_use), .mx_start(mx_start), .mx_done(mx_done),
      .br_ctrl(br_ctrl_a), .br_addr(br_addr_a), .pc_stall(pc_stall_a),
      .if_id_stall(if_id_stall_a), .if_id_flush(if_id_flush_a),
      .id_ex_flush(id_ex_flush_a), .mx_kill(mx_kill_a), .mx_timeout(mx_timeout_a)
   );

   pc_redirect_ctrl #(.LOAD_LAT(1), .MX_TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst),
      .trap_req(trap_req), .trap_vec(trap_vec),
      .mret_req(mret_req), .mepc(mepc),
      .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
      .id_jal(id_jal), .id_jal_target(id_jal_target),
      .id_load_use(id_load_use), .mx_start(mx_start), .mx_done(mx_done),
      .br_ctrl(br_ctrl_b), .br_addr(br_addr_b), .pc_stall(pc_stall_b),
      .if_id_stall(if_id_stall_b), .if_id_flush(if_id_flush_b),
      .id_ex_flush(id_ex_flush_b), .mx_kill(mx_kill_b), .mx_timeout(mx_timeout_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      trap_req = 0; mret_req = 0; ex_br_taken = 0; id_jal = 0;
      id_load_use = 0; mx_start = 0; mx_done = 0;
      trap_vec = 0; mepc = 0; ex_br_target = 0; id_jal_target = 0;
   endtask

   // Advance to 1 time unit after the next rising edge and clear requests.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b0;
      trap_req = 1; trap_vec = 32'h1234_5678;
      #2;
      chk("rst_br_ctrl", br_ctrl_a, 0);
      chk("rst_br_addr", br_addr_a, 0);
      chk("rst_if_id_flush", if_id_flush_a, 0);
      chk("rst_pc_stall", pc_stall_a, 0);
      chk("rst_mx_timeout", mx_timeout_b, 0);
      idle();
      #1 rst = 1'b1;
      tick();

      // EX branch beats ID jal; redirect overrides load-use stall.
      ex_br_taken = 1; ex_br_target = 32'h0000_0120;
      id_jal = 1; id_jal_target = 32'h0000_0200; id_load_use = 1;
      #1;
      chk("br_ctrl", br_ctrl_a, 1);
      chk("br_addr", br_addr_a, 32'h120);
      chk("br_if_id_flush", if_id_flush_a, 1);
      chk("br_id_ex_flush", id_ex_flush_a, 1);
      chk("br_pc_stall", pc_stall_a, 0);
      chk("br_if_id_stall", if_id_stall_a, 0);
      tick();

      // Back-to-back redirect: jal alone, misaligned target.
      id_jal = 1; id_jal_target = 32'h0000_0203;
      #1;
      chk("jal_br_ctrl", br_ctrl_a, 1);
      chk("jal_br_addr", br_addr_a, 32'h200);
      chk("jal_if_id_flush", if_id_flush_a, 1);
      chk("jal_id_ex_flush", id_ex_flush_a, 0);
      tick();

      // Load-use: 3 stall cycles on a, 1 on b.
      id_load_use = 1;
      #1;
      chk("lu0_pc_stall_a", pc_stall_a, 1);
      chk("lu0_id_ex_flush_a", id_ex_flush_a, 1);
      chk("lu0_if_id_stall_a", if_id_stall_a, 1);
      chk("lu0_pc_stall_b", pc_stall_b, 1);
      tick();
      #1;
      chk("lu1_pc_stall_a", pc_stall_a, 1);
      chk("lu1_pc_stall_b", pc_stall_b, 0);
      tick();
      id_jal = 1; id_jal_target = 32'h0000_0400;
      #1;
      chk("lu2_jal_ignored_a", br_ctrl_a, 0);
      chk("lu2_pc_stall_a", pc_stall_a, 1);
      chk("lu2_id_ex_flush_a", id_ex_flush_a, 1);
      chk("lu2_jal_taken_b", br_ctrl_b, 1);
      tick();
      #1;
      chk("lu3_pc_stall_a", pc_stall_a, 0);
      chk("lu3_id_ex_flush_a", id_ex_flush_a, 0);
      tick();

      // Matrix wait: done after 10 cycles on a; b times out after 4 stalls.
      mx_start = 1;
      #1;
      chk("mx0_pc_stall_a", pc_stall_a, 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 10) mx_done = 1;
         #1;
         chk($sformatf("mx%0d_pc_stall_a", i), pc_stall_a, 1);
         chk($sformatf("mx%0d_pc_stall_b", i), pc_stall_b, (i <= 4) ? 1 : 0);
         chk($sformatf("mx%0d_mx_kill_b", i), mx_kill_b, (i == 5) ? 1 : 0);
         chk($sformatf("mx%0d_mx_timeout_b", i), mx_timeout_b, (i >= 5) ? 1 : 0);
      end
      tick();
      #1;
      chk("mx11_pc_stall_a", pc_stall_a, 0);
      chk("mx11_mx_timeout_a", mx_timeout_a, 0);
      chk("mx11_mx_kill_a", mx_kill_a, 0);
      tick();

      // Trap + mret while in MX_WAIT: trap wins, kill pulses.
      mx_start = 1;
      tick();
      trap_req = 1; trap_vec = 32'h8000_0003; mret_req = 1; mepc = 32'h0000_0040;
      #1;
      chk("mxtrap_br_addr", br_addr_a, 32'h8000_0000);
      chk("mxtrap_mx_kill_a", mx_kill_a, 1);
      chk("mxtrap_pc_stall_a", pc_stall_a, 0);
      chk("mxtrap_id_ex_flush_a", id_ex_flush_a, 1);
      tick();
      #1;
      chk("mxtrap_next_pc_stall", pc_stall_a, 0);
      chk("mxtrap_next_mx_kill", mx_kill_a, 0);
      tick();

      // b: mx_done coincides with the timeout cycle -> no kill.
      mx_start = 1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) mx_done = 1;
      end
      tick();
      #1;
      chk("done_vs_to_mx_kill_b", mx_kill_b, 0);
      chk("done_vs_to_pc_stall_b", pc_stall_b, 0);
      tick();

      // Async reset mid LU_STALL, then a full stall afterwards.
      id_load_use = 1;
      tick();
      #1;
      chk("prerst_pc_stall_a", pc_stall_a, 1);
      #1 rst = 1'b0;
      #1;
      chk("async_rst_pc_stall", pc_stall_a, 0);
      chk("async_rst_id_ex_flush", id_ex_flush_a, 0);
      chk("async_rst_mx_timeout_b", mx_timeout_b, 0);
      #2 rst = 1'b1;
      tick();
      #1;
      chk("postrst_pc_stall_a", pc_stall_a, 0);
      tick();
      id_load_use = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("postrst_lu%0d_pc_stall_a", i), pc_stall_a, (i < 3) ? 1 : 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
